calib_follower_fsm: RTL and testbench

//  Follower-side counterpart of the leader calibration FSM. Sits in the AIB-AXI follower

---
 rtl/calib_pkg.sv | 37 +++
 rtl/calib_avmm_cmd.sv | 117 +++++++++++
 rtl/calib_follower_fsm.sv | 197 +++++++++++++++++++
 tb/tb_calib_follower_fsm.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calib_pkg.sv
// Shared types, config table constants and AVMM address packing for the follower
// calibration sequencer. Readback checking is selected by CALIB_READBACK_EN.
package calib_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_CFG_WR    = 4'd1;
  localparam state_t ST_CFG_RD    = 4'd2;
  localparam state_t ST_CFG_NEXT  = 4'd3;
  localparam state_t ST_RSTN_REL  = 4'd4;
  localparam state_t ST_LOCK_REQ  = 4'd5;
  localparam state_t ST_WAIT_LINK = 4'd6;
  localparam state_t ST_WAIT_CONF = 4'd7;
  localparam state_t ST_DONE      = 4'd8;
  localparam state_t ST_ERR       = 4'd9;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WR,
    CMD_RD,
    CMD_RDV
  } cmd_phase_t;

  localparam int CFG_NUM = 3;

  localparam logic [10:0] CFG_OFFSET [CFG_NUM] = '{11'h208, 11'h210, 11'h218};
  localparam logic [31:0] CFG_DATA   [CFG_NUM] = '{32'h0000_0003, 32'h0000_000B, 32'h0000_0001};

  // Gen2 replaces the data word of the first table entry (offset 0x208).
  localparam logic [31:0] CFG_GEN2_208 = 32'h0100_0003;

  function automatic logic [16:0] avmm_addr(input logic [5:0] ch, input logic [10:0] offset);
    return {ch, offset};
  endfunction

endpackage

// File: rtl/calib_avmm_cmd.sv
// Single-command AVMM initiator: one write or read at a time, held stable under
// waitrequest. The read path exists only when CALIB_READBACK_EN is defined.
module calib_avmm_cmd
  import calib_pkg::*;
#(
  parameter int AW = 17,
  parameter int DW = 32,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] avmm_address_o,
  output logic          avmm_read_o,
  output logic          avmm_write_o,
  output logic [DW-1:0] avmm_writedata_o,
  output logic [BW-1:0] avmm_byteenable_o,
  input  logic [DW-1:0] avmm_readdata_i,
  input  logic          avmm_readdatavalid_i,
  input  logic          avmm_waitrequest_i
);

  cmd_phase_t phase;

`ifdef CALIB_READBACK_EN
  logic read_q;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      phase            <= CMD_IDLE;
      avmm_write_o     <= 1'b0;
      read_q           <= 1'b0;
      avmm_address_o   <= '0;
      avmm_writedata_o <= '0;
    end else begin
      case (phase)
        CMD_IDLE: begin
          if (wr_req) begin
            phase            <= CMD_WR;
            avmm_write_o     <= 1'b1;
            avmm_address_o   <= addr;
            avmm_writedata_o <= wdata;
          end else if (rd_req) begin
            phase          <= CMD_RD;
            read_q         <= 1'b1;
            avmm_address_o <= addr;
          end
        end
        CMD_WR: begin
          if (!avmm_waitrequest_i) begin
            phase        <= CMD_IDLE;
            avmm_write_o <= 1'b0;
          end
        end
        CMD_RD: begin
          if (!avmm_waitrequest_i) begin
            phase  <= CMD_RDV;
            read_q <= 1'b0;
          end
        end
        CMD_RDV: begin
          if (avmm_readdatavalid_i) phase <= CMD_IDLE;
        end
        default: phase <= CMD_IDLE;
      endcase
    end
  end

  assign avmm_read_o = read_q;
  assign rdata       = avmm_readdata_i;
  assign done        = ((phase == CMD_WR) && !avmm_waitrequest_i) ||
                       ((phase == CMD_RDV) && avmm_readdatavalid_i);
`else
  logic unused_rd;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      phase            <= CMD_IDLE;
      avmm_write_o     <= 1'b0;
      avmm_address_o   <= '0;
      avmm_writedata_o <= '0;
    end else begin
      case (phase)
        CMD_IDLE: begin
          if (wr_req) begin
            phase            <= CMD_WR;
            avmm_write_o     <= 1'b1;
            avmm_address_o   <= addr;
            avmm_writedata_o <= wdata;
          end
        end
        CMD_WR: begin
          if (!avmm_waitrequest_i) begin
            phase        <= CMD_IDLE;
            avmm_write_o <= 1'b0;
          end
        end
        default: phase <= CMD_IDLE;
      endcase
    end
  end

  assign avmm_read_o = 1'b0;
  assign rdata       = '0;
  assign done        = (phase == CMD_WR) && !avmm_waitrequest_i;
  assign unused_rd   = ^{rd_req, avmm_readdata_i, avmm_readdatavalid_i};
`endif

  assign avmm_byteenable_o = (avmm_write_o || avmm_read_o) ? {BW{1'b1}} : '0;

endmodule

// File: rtl/calib_follower_fsm.sv
// Follower-side calibration sequencer: programs per-channel AIB config over AVMM,
// releases adapter resets, requests DCC/DLL lock, waits for link, then raises MAC ready.
// Define CALIB_READBACK_EN to verify every config write with a readback.
//
// state     | meaning
// IDLE      | one cycle after reset before the config walk
// CFG_WR    | config write for (ch, idx) in flight
// CFG_RD    | readback of the write just accepted (CALIB_READBACK_EN only)
// CFG_NEXT  | step idx, then ch; leave after the last active channel
// RSTN_REL  | release adapter resets on active channels
// LOCK_REQ  | raise TX/RX DCC/DLL lock requests
// WAIT_LINK | wait for TX and RX transfer-enable on all active channels
// WAIT_CONF | link up, wait for user configuration done
// DONE      | MAC ready; link loss falls back to WAIT_LINK
// ERR       | timeout or readback mismatch; sticky until rst
module calib_follower_fsm #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int ACTIVE_CHNLS   = 2,
  parameter int GEN2_MODE      = 1,
  parameter int AVMM_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_conf_done,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  output logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
  output logic                      calib_done,
  output logic                      calib_err,
  output logic [16:0]               avmm_address_o,
  output logic                      avmm_read_o,
  output logic                      avmm_write_o,
  output logic [AVMM_WIDTH-1:0]     avmm_writedata_o,
  output logic [BYTE_WIDTH-1:0]     avmm_byteenable_o,
  input  logic [AVMM_WIDTH-1:0]     avmm_readdata_i,
  input  logic                      avmm_readdatavalid_i,
  input  logic                      avmm_waitrequest_i
);

  import calib_pkg::*;

  localparam logic [TOTAL_CHNL_NUM-1:0] ACT_MASK =
    {TOTAL_CHNL_NUM{1'b1}} >> (TOTAL_CHNL_NUM - ACTIVE_CHNLS);
  localparam logic [5:0]  LAST_CH  = 6'(ACTIVE_CHNLS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [5:0]            ch;
  logic [1:0]            idx;
  logic [15:0]           tmo_cnt;
  logic                  link_up, counting, cmd_done, abort;
  logic [10:0]           cfg_off;
  logic [31:0]           cfg_word;
  logic [AVMM_WIDTH-1:0] cmd_wdata, cmd_rdata;

  // Inactive channel bits of the transfer enables are ignored.
  assign link_up = (&(sl_tx_transfer_en | ~ACT_MASK)) && (&(sl_rx_transfer_en | ~ACT_MASK));

  assign counting = (state == ST_CFG_WR) || (state == ST_CFG_RD) ||
                    (state == ST_WAIT_LINK) || (state == ST_WAIT_CONF);

  always_comb begin
    cfg_off  = CFG_OFFSET[0];
    cfg_word = (GEN2_MODE != 0) ? CFG_GEN2_208 : CFG_DATA[0];
    case (idx)
      2'd1: begin
        cfg_off  = CFG_OFFSET[1];
        cfg_word = CFG_DATA[1];
      end
      2'd2: begin
        cfg_off  = CFG_OFFSET[2];
        cfg_word = CFG_DATA[2];
      end
      default: ;
    endcase
  end

  assign cmd_wdata = AVMM_WIDTH'(cfg_word);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_CFG_WR;
`ifdef CALIB_READBACK_EN
      ST_CFG_WR: if (cmd_done) state_nxt = ST_CFG_RD;
      ST_CFG_RD: if (cmd_done) state_nxt = (cmd_rdata == cmd_wdata) ? ST_CFG_NEXT : ST_ERR;
`else
      ST_CFG_WR: if (cmd_done) state_nxt = ST_CFG_NEXT;
`endif
      ST_CFG_NEXT: state_nxt = ((ch == LAST_CH) && (idx == 2'd2)) ? ST_RSTN_REL : ST_CFG_WR;
      ST_RSTN_REL: state_nxt = ST_LOCK_REQ;
      ST_LOCK_REQ: state_nxt = ST_WAIT_LINK;
      ST_WAIT_LINK: if (link_up) state_nxt = ST_WAIT_CONF;
      // Link loss wins over a coincident i_conf_done.
      ST_WAIT_CONF: begin
        if (!link_up)         state_nxt = ST_WAIT_LINK;
        else if (i_conf_done) state_nxt = ST_DONE;
      end
      ST_DONE: if (!link_up) state_nxt = ST_WAIT_LINK;
      ST_ERR: state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
    if (counting && (state_nxt == state) && (tmo_cnt == TMO_LAST)) state_nxt = ST_ERR;
  end

  assign abort = (state_nxt == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= ST_IDLE;
      ch                     <= '0;
      idx                    <= '0;
      tmo_cnt                <= '0;
      ns_adapter_rstn        <= '0;
      ns_mac_rdy             <= '0;
      sl_rx_dcc_dll_lock_req <= '0;
      sl_tx_dcc_dll_lock_req <= '0;
      calib_done             <= 1'b0;
      calib_err              <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (counting && (state_nxt == state)) ? tmo_cnt + 16'd1 : 16'd0;
      if (state_nxt == ST_ERR) begin
        ns_adapter_rstn        <= '0;
        ns_mac_rdy             <= '0;
        sl_rx_dcc_dll_lock_req <= '0;
        sl_tx_dcc_dll_lock_req <= '0;
        calib_done             <= 1'b0;
        calib_err              <= 1'b1;
      end else begin
        case (state)
          ST_CFG_NEXT: begin
            if (idx == 2'd2) begin
              idx <= 2'd0;
              ch  <= ch + 6'd1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          ST_RSTN_REL: ns_adapter_rstn <= ACT_MASK;
          ST_LOCK_REQ: begin
            sl_rx_dcc_dll_lock_req <= ACT_MASK;
            sl_tx_dcc_dll_lock_req <= ACT_MASK;
          end
          ST_WAIT_CONF: begin
            if (state_nxt == ST_DONE) begin
              ns_mac_rdy <= ACT_MASK;
              calib_done <= 1'b1;
            end
          end
          ST_DONE: begin
            if (state_nxt == ST_WAIT_LINK) begin
              ns_mac_rdy <= '0;
              calib_done <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifndef CALIB_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^cmd_rdata;
`endif

  calib_avmm_cmd #(
    .AW (17),
    .DW (AVMM_WIDTH),
    .BW (BYTE_WIDTH)
  ) u_cmd (
    .clk                  (clk),
    .rst                  (rst),
    .abort                (abort),
    .wr_req               (state == ST_CFG_WR),
    .rd_req               (state == ST_CFG_RD),
    .addr                 (avmm_addr(ch, cfg_off)),
    .wdata                (cmd_wdata),
    .done                 (cmd_done),
    .rdata                (cmd_rdata),
    .avmm_address_o       (avmm_address_o),
    .avmm_read_o          (avmm_read_o),
    .avmm_write_o         (avmm_write_o),
    .avmm_writedata_o     (avmm_writedata_o),
    .avmm_byteenable_o    (avmm_byteenable_o),
    .avmm_readdata_i      (avmm_readdata_i),
    .avmm_readdatavalid_i (avmm_readdatavalid_i),
    .avmm_waitrequest_i   (avmm_waitrequest_i)
  );

endmodule

// File: tb/tb_calib_follower_fsm.sv
// Bench for calib_follower_fsm: randomized AVMM stalls and link/conf timing against
// an arithmetic model of the config walk and link-tracking behaviour.
module tb_calib_follower_fsm;

  localparam int ACT = 2;
  localparam int TMO = 100;
  localparam logic [23:0] MASK = 24'((1 << ACT) - 1);

  logic        clk = 1'b0;
  logic        rst, i_conf_done;
  logic [23:0] tx_en, rx_en;
  logic [23:0] ns_adapter_rstn, ns_mac_rdy, rx_lock, tx_lock;
  logic        calib_done, calib_err;
  logic [16:0] avmm_address_o;
  logic        avmm_read_o, avmm_write_o;
  logic [31:0] avmm_writedata_o, avmm_readdata_i;
  logic [3:0]  avmm_byteenable_o;
  logic        avmm_readdatavalid_i, avmm_waitrequest_i;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  calib_follower_fsm #(
    .TOTAL_CHNL_NUM (24),
    .ACTIVE_CHNLS   (ACT),
    .GEN2_MODE      (1),
    .AVMM_WIDTH     (32),
    .BYTE_WIDTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_conf_done            (i_conf_done),
    .sl_tx_transfer_en      (tx_en),
    .sl_rx_transfer_en      (rx_en),
    .ns_adapter_rstn        (ns_adapter_rstn),
    .ns_mac_rdy             (ns_mac_rdy),
    .sl_rx_dcc_dll_lock_req (rx_lock),
    .sl_tx_dcc_dll_lock_req (tx_lock),
    .calib_done             (calib_done),
    .calib_err              (calib_err),
    .avmm_address_o         (avmm_address_o),
    .avmm_read_o            (avmm_read_o),
    .avmm_write_o           (avmm_write_o),
    .avmm_writedata_o       (avmm_writedata_o),
    .avmm_byteenable_o      (avmm_byteenable_o),
    .avmm_readdata_i        (avmm_readdata_i),
    .avmm_readdatavalid_i   (avmm_readdatavalid_i),
    .avmm_waitrequest_i     (avmm_waitrequest_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // AVMM responder: planned stalls per command, logs accepted writes.
  logic [48:0] wlog[$];
  int          stall_plan [64];
  int          n_cmd = 0, stall_left = 0, wr_rises = 0;
  bit          busy = 0, rd_pend = 0, prev_wr = 0, first_rd_bad = 0;
  logic [16:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] last_wdata = '0;

  initial begin
    avmm_waitrequest_i   = 1'b0;
    avmm_readdatavalid_i = 1'b0;
    avmm_readdata_i      = '0;
  end

  always @(negedge clk) begin
    avmm_readdatavalid_i = 1'b0;
    avmm_readdata_i      = $urandom;
    if (rst) begin
      busy = 0; rd_pend = 0; prev_wr = 0; n_cmd = 0;
      avmm_waitrequest_i = 1'b0;
    end else begin
      if (avmm_write_o && !prev_wr) wr_rises++;
      prev_wr = avmm_write_o;
      if (rd_pend) begin
        avmm_readdatavalid_i = 1'b1;
        avmm_readdata_i      = first_rd_bad ? 32'hDEAD_BEEF : last_wdata;
        first_rd_bad = 0;
        rd_pend = 0;
      end
      if (avmm_write_o || avmm_read_o) begin
        if (!busy) begin
          busy = 1;
          stall_left = stall_plan[n_cmd % 64];
          n_cmd++;
          cmd_addr = avmm_address_o;
          cmd_data = avmm_writedata_o;
        end else begin
          chk("hold_addr", 64'(avmm_address_o), 64'(cmd_addr));
          if (avmm_write_o) chk("hold_data", 64'(avmm_writedata_o), 64'(cmd_data));
        end
        chk("byteenable", 64'(avmm_byteenable_o), 64'(4'hF));
        if (stall_left > 0) begin
          avmm_waitrequest_i = 1'b1;
          stall_left--;
        end else begin
          avmm_waitrequest_i = 1'b0;
          busy = 0;
          if (avmm_write_o) begin
            wlog.push_back({avmm_address_o, avmm_writedata_o});
            last_wdata = avmm_writedata_o;
          end
          if (avmm_read_o) rd_pend = 1;
        end
      end else begin
        avmm_waitrequest_i = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] junk, prev_rstn;
    logic [48:0] got;
    logic [16:0] exp_addr;
    logic [31:0] exp_data;
    bit          seen;
    int          lat, side, b;

    rst = 1'b1; i_conf_done = 1'b0; tx_en = '0; rx_en = '0;
    for (int i = 0; i < 64; i++) stall_plan[i] = $urandom_range(0, 3);
    stall_plan[1] = 5;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rstn",  64'(ns_adapter_rstn), 64'(0));
    chk("rst_mac",   64'(ns_mac_rdy), 64'(0));
    chk("rst_rxlk",  64'(rx_lock), 64'(0));
    chk("rst_txlk",  64'(tx_lock), 64'(0));
    chk("rst_done",  64'(calib_done), 64'(0));
    chk("rst_err",   64'(calib_err), 64'(0));
    chk("rst_wr",    64'(avmm_write_o), 64'(0));
    chk("rst_rd",    64'(avmm_read_o), 64'(0));
    chk("rst_be",    64'(avmm_byteenable_o), 64'(0));
    wlog.delete(); wr_rises = 0;
    rst = 1'b0;

    // Config walk until lock requests appear
    seen = 0; prev_rstn = '0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (rx_lock != 0) seen = 1; else prev_rstn = ns_adapter_rstn;
    end
    chk("lock_seen", 64'(seen), 64'(1));
    chk("rstn_before_lock", 64'(prev_rstn), 64'(MASK));
    chk("wr_count", 64'(wlog.size()), 64'(3 * ACT));
    chk("wr_pulses", 64'(wr_rises), 64'(3 * ACT));
    for (int e = 0; e < 3 * ACT; e++) begin
      got = (e < wlog.size()) ? wlog[e] : 49'h0;
      exp_addr = 17'((e / 3) * 2048 + 'h208 + 8 * (e % 3));
      exp_data = (e % 3 == 0) ? 32'h0100_0003 : ((e % 3 == 1) ? 32'h0000_000B : 32'h0000_0001);
      chk("wr_addr", 64'(got[48:32]), 64'(exp_addr));
      chk("wr_data", 64'(got[31:0]), 64'(exp_data));
    end
    chk("rstn_act", 64'(ns_adapter_rstn), 64'(MASK));
    chk("txlk_act", 64'(tx_lock), 64'(MASK));
    chk("rxlk_act", 64'(rx_lock), 64'(MASK));
    chk("mac_pre",  64'(ns_mac_rdy), 64'(0));
`ifndef CALIB_READBACK_EN
    chk("read_tied", 64'(avmm_read_o), 64'(0));
`endif

    // Link bring-up with random junk on inactive bits
    repeat ($urandom_range(3, 20)) begin
      @(negedge clk);
      junk = 24'($urandom) & ~MASK;
      tx_en = junk; rx_en = 24'($urandom) & ~MASK;
    end
    b = $urandom_range(0, ACT - 1);
    tx_en = MASK | (24'($urandom) & ~MASK);
    rx_en = (MASK & ~(24'(1) << b)) | (24'($urandom) & ~MASK);
    repeat (3) @(negedge clk);
    chk("partial_link_done", 64'(calib_done), 64'(0));
    rx_en = rx_en | MASK;
    repeat ($urandom_range(2, 15)) @(negedge clk);
    chk("no_conf_mac", 64'(ns_mac_rdy), 64'(0));
    i_conf_done = 1'b1;
    lat = 0; seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (ns_mac_rdy != 0 || calib_done) begin seen = 1; lat = c; end
    end
    chk("conf_lat", 64'(lat), 64'(1));
    chk("mac_up",   64'(ns_mac_rdy), 64'(MASK));
    chk("done_up",  64'(calib_done), 64'(1));

    // Directed drop of rx[1], then random drops
    for (int it = 0; it < 5; it++) begin
      side = (it == 0) ? 1 : $urandom_range(0, 1);
      b    = (it == 0) ? 1 : $urandom_range(0, ACT - 1);
      if (side == 1) rx_en[b] = 1'b0; else tx_en[b] = 1'b0;
      @(negedge clk);
      chk("drop_mac",  64'(ns_mac_rdy), 64'(0));
      chk("drop_done", 64'(calib_done), 64'(0));
      chk("drop_rstn", 64'(ns_adapter_rstn), 64'(MASK));
      chk("drop_lock", 64'(rx_lock & tx_lock), 64'(MASK));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx_en = rx_en | MASK; tx_en = tx_en | MASK;
      lat = 0; seen = 0;
      for (int c = 1; c <= 10 && !seen; c++) begin
        @(negedge clk);
        if (ns_mac_rdy == MASK && calib_done) begin seen = 1; lat = c; end
      end
      chk("relink_lat", 64'(lat), 64'(2));
    end

    // Inactive-bit toggles must not disturb DONE
    repeat (5) begin
      tx_en = MASK | (24'($urandom) & ~MASK);
      rx_en = MASK | (24'($urandom) & ~MASK);
      @(negedge clk);
    end
    chk("inactive_toggle", 64'({ns_mac_rdy, 7'b0, calib_done}), 64'({MASK, 8'h01}));

    // Link loss coincident with i_conf_done in WAIT_CONF
    i_conf_done = 1'b0;
    rx_en[0] = 1'b0;
    @(negedge clk);
    rx_en[0] = 1'b1;
    @(negedge clk);
    tx_en[1] = 1'b0; i_conf_done = 1'b1;
    @(negedge clk);
    chk("simul_mac",  64'(ns_mac_rdy), 64'(0));
    chk("simul_done", 64'(calib_done), 64'(0));
    @(negedge clk);
    chk("simul_hold", 64'(ns_mac_rdy), 64'(0));
    tx_en[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("simul_recover", 64'(ns_mac_rdy), 64'(MASK));
    chk("no_extra_wr", 64'(wlog.size()), 64'(3 * ACT));

    // Reset mid-command, then timeout in WAIT_LINK
    rst = 1'b1; i_conf_done = 1'b0; tx_en = '0; rx_en = '0;
    repeat (2) @(negedge clk);
    stall_plan[0] = 8;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (avmm_write_o) seen = 1;
    end
    chk("stall_wr_seen", 64'(seen), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midcmd_wr",   64'(avmm_write_o), 64'(0));
    chk("midcmd_addr", 64'(avmm_address_o), 64'(0));
    chk("midcmd_be",   64'(avmm_byteenable_o), 64'(0));
    stall_plan[0] = 0;
    @(negedge clk);
    wlog.delete(); wr_rises = 0;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (rx_lock != 0) seen = 1;
    end
    chk("lock_seen2", 64'(seen), 64'(1));
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", 64'(calib_err), 64'(0));
    @(negedge clk);
    chk("tmo_err",  64'(calib_err), 64'(1));
    chk("tmo_rstn", 64'(ns_adapter_rstn), 64'(0));
    chk("tmo_lock", 64'(rx_lock | tx_lock), 64'(0));
    tx_en = '1; rx_en = '1; i_conf_done = 1'b1;
    repeat (20) @(negedge clk);
    chk("err_sticky", 64'(calib_err), 64'(1));
    chk("err_mac",    64'({ns_mac_rdy, 7'b0, calib_done}), 64'(0));
    chk("err_nowr",   64'(wlog.size()), 64'(3 * ACT));
    rst = 1'b1;
    @(negedge clk);
    chk("err_cleared", 64'(calib_err), 64'(0));

`ifdef CALIB_READBACK_EN
    // First readback returns a wrong word
    first_rd_bad = 1; i_conf_done = 1'b0; tx_en = '0; rx_en = '0;
    @(negedge clk);
    wlog.delete(); wr_rises = 0;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (calib_err) seen = 1;
    end
    chk("rb_err", 64'(seen), 64'(1));
    repeat (20) @(negedge clk);
    chk("rb_one_write", 64'(wlog.size()), 64'(1));
    chk("rb_idle", 64'({avmm_write_o, avmm_read_o}), 64'(0));
    chk("rb_rstn", 64'(ns_adapter_rstn), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
